mem_resp_ctrl: RTL

MEM_RESP_CTRL -- requirements
Module: mem_resp_ctrl

---
 rtl/mem_resp_ctrl.sv | 133 +++++++++++++
 1 files changed

// File: rtl/mem_resp_ctrl.sv
// mem_resp_ctrl: three-state controller (IDLE -> ACCESS -> DONE) between the
// control-unit stage and a single-port memory.
// Accepts a read or write request, latches the address, data and direction,
// holds the pipeline until the memory acknowledges, and then returns read data
// with a one-cycle valid pulse.
// Optional feature macro: MEM_RESP_TIMEOUT_EN. When it is defined, an access
// that is never acknowledged is aborted after TIMEOUT cycles and ERR is set.
module mem_resp_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              CK3,
  input  logic              RESET,
  input  logic              MR_IN,
  input  logic              MW_IN,
  input  logic [ADDR_W-1:0] ADDR_IN,
  input  logic [DATA_W-1:0] WDATA_IN,
  output logic              HOLD,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [ADDR_W-1:0] MEM_ADDR,
  output logic [DATA_W-1:0] MEM_WDATA,
  input  logic [DATA_W-1:0] MEM_RDATA,
  input  logic              MEM_ACK,
  output logic [DATA_W-1:0] RDATA_OUT,
  output logic              RDATA_VALID,
  output logic              ERR
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t              state_reg, state_next;
  logic                accept;
  logic                timeout_hit;
  logic [ADDR_W-1:0]   addr_reg;
  logic [DATA_W-1:0]   wdata_reg;
  logic [DATA_W-1:0]   rdata_reg;
  logic                we_reg;

`ifdef MEM_RESP_TIMEOUT_EN
  // Counter value seen in the last ACCESS cycle allowed before the abort.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_reg;
  logic       err_reg;

  // The abort fires only when the memory does not acknowledge in that cycle.
  assign timeout_hit = (cnt_reg == TO_LAST) && !MEM_ACK;

  // Count ACCESS cycles from zero for each new access; latch the error flag.
  always_ff @(posedge CK3 or posedge RESET) begin
    if (RESET) begin
      cnt_reg <= '0;
      err_reg <= 1'b0;
    end else begin
      if (accept)
        cnt_reg <= '0;
      else if (state_reg == ACCESS)
        cnt_reg <= cnt_reg + 8'd1;
      if (state_reg == ACCESS && timeout_hit)
        err_reg <= 1'b1;
    end
  end

  assign ERR = err_reg;
`else
  assign timeout_hit = 1'b0;
  assign ERR         = 1'b0;
`endif

  // State register.
  always_ff @(posedge CK3 or posedge RESET) begin
    if (RESET)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  // Next-state logic; requests are only looked at in IDLE, so DONE ignores them.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      IDLE: begin
        if (MR_IN || MW_IN) begin
          state_next = ACCESS;
          accept     = 1'b1;
        end
      end
      ACCESS: begin
        if (MEM_ACK || timeout_hit)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Request latch and read-data capture. A write takes priority when both
  // requests arrive together, because the direction is taken from MW_IN.
  always_ff @(posedge CK3 or posedge RESET) begin
    if (RESET) begin
      addr_reg  <= '0;
      wdata_reg <= '0;
      we_reg    <= 1'b0;
      rdata_reg <= '0;
    end else begin
      if (accept) begin
        addr_reg  <= ADDR_IN;
        wdata_reg <= WDATA_IN;
        we_reg    <= MW_IN;
      end
      if (state_reg == ACCESS && !we_reg) begin
        if (MEM_ACK)
          rdata_reg <= MEM_RDATA;
        else if (timeout_hit)
          rdata_reg <= '1;
      end
    end
  end

  // HOLD is masked by RESET so that requests raised during reset do not stall.
  assign HOLD        = (state_reg == ACCESS) ||
                       ((state_reg == IDLE) && (MR_IN || MW_IN) && !RESET);
  assign MEM_CS      = (state_reg == ACCESS);
  assign MEM_WE      = (state_reg == ACCESS) && we_reg;
  assign MEM_ADDR    = addr_reg;
  assign MEM_WDATA   = wdata_reg;
  assign RDATA_OUT   = rdata_reg;
  assign RDATA_VALID = (state_reg == DONE) && !we_reg;

endmodule
